glyph_blitter: RTL and testbench
================================

GLYPH_BLITTER -- requirements
Module: glyph_blitter

Interface
REQ-001 SHALL have parameter GLYPH_W, default 4, meaning glyph width in cells.
REQ-002 SHALL have parameter GLYPH_H, default 4, meaning glyph height in cells.
REQ-003 SHALL have parameter X_W, default 8, meaning screen x coordinate width.
REQ-004 SHALL have parameter Y_W, default 7, meaning screen y coordinate width.
REQ-005 SHALL have parameter COLOUR_W, default 3, meaning colour width.
REQ-006 SHALL have parameter SCREEN_W, default 160, meaning visible columns.
REQ-007 SHALL have parameter SCREEN_H, default 120, meaning visible rows.
REQ-008 SHALL have one clock and a synchronous, active-high reset:
clk  in  1  clock, all logic on rising edge.
reset  in  1  synchronous, active-high reset.
REQ-009 SHALL have the following ports:
start  in  1  request draw, sampled in IDLE only.
abort  in  1  terminate the current draw.
glyph  in  GLYPH_W*GLYPH_H  bitmap; bit r*GLYPH_W+c is cell (c,r).
x0  in  X_W  origin x.
y0  in  Y_W  origin y.
fg  in  COLOUR_W  set-bit colour.
bg  in  COLOUR_W  clear-bit colour.
scale2  in  1  0 = 1x, 1 = 2x magnification.
transparent  in  1  1 = clear bits not plotted.
plot_x  out  X_W  pixel x.
plot_y  out  Y_W  pixel y.
plot_colour  out  COLOUR_W  pixel colour.
plot  out  1  write enable for the current pixel.
busy  out  1  draw in progress.
done  out  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement states IDLE, DRAW, DONE.
REQ-011 IDLE with start=1 SHALL capture glyph, x0, y0, fg, bg, scale2 and transparent into registers and enter DRAW next cycle; later input changes SHALL NOT affect the draw.
REQ-012 Scale S SHALL be 1 or 2; output extent SHALL be GLYPH_W*S by GLYPH_H*S; DRAW SHALL last exactly N = GLYPH_W*GLYPH_H*S*S cycles, one output pixel per cycle.
REQ-013 Scan order SHALL be row-major with the output offset ox fastest, starting at (0,0); the source bit SHALL be glyph[(oy/S)*GLYPH_W + ox/S].
REQ-014 Outputs SHALL be registered; the pixel for scan index k SHALL appear on outputs in DRAW cycle k (first DRAW cycle = pixel (0,0)).
REQ-015 plot_x = x0+ox and plot_y = y0+oy, computed one bit wider than X_W/Y_W; plot SHALL be 0 when the wide sum >= SCREEN_W or >= SCREEN_H (clipping, no wrap).
REQ-016 plot_colour SHALL be fg for a set bit and bg for a clear bit; when transparent=1 and the bit is clear, plot SHALL be 0 while the scan still advances one cycle.
REQ-017 After the last pixel, the FSM SHALL enter DONE for one cycle with done=1 and plot=0, then return to IDLE.
REQ-018 busy SHALL be 1 in DRAW and DONE, and 0 in IDLE; start SHALL be ignored while busy.
REQ-019 abort=1 in DRAW or DONE SHALL return the FSM to IDLE next cycle with plot=0 and done=0; abort SHALL take precedence over completion in the same cycle.
REQ-020 start and abort both asserted in IDLE: abort SHALL win and no draw SHALL begin.
REQ-021 In IDLE, plot SHALL be 0; plot_x, plot_y and plot_colour SHALL hold their last values.

Reset
REQ-022 reset SHALL force IDLE with plot=0, busy=0, done=0, plot_x=0, plot_y=0, plot_colour=0 and scan counters at 0, on the next clock edge.
REQ-023 reset asserted mid-draw SHALL abandon the draw with no done pulse; reset SHALL dominate start and abort.

Structure
REQ-024 The FSM state encoding and the SCALE_1X/SCALE_2X constants SHALL live in the shared package pixeltyper_pkg.
REQ-025 A single sub-module, glyph_scan_counter, SHALL generate ox/oy and a last flag for parameterised extent and scale; the FSM and pixel datapath SHALL remain in glyph_blitter.

Verification
REQ-026 Default parameters, glyph=16'h8001, x0=100, y0=10, fg=3'b111, bg=3'b001, scale2=0, transparent=0 -> 16 pixels, plot=1 throughout; (100,10) and (103,13) are 3'b111, the rest 3'b001; done one cycle after (103,13).
REQ-027 Same stimulus with transparent=1 -> still 16 DRAW cycles; plot=1 only at (100,10) and (103,13).
REQ-028 scale2=1, glyph=16'h0001, x0=0, y0=0 -> 64 cycles; fg at (0,0), (1,0), (0,1) and (1,1) only; done at cycle 65.
REQ-029 x0=158, y0=118, glyph=16'hFFFF -> plot=1 only for x in 158..159 and y in 118..119 (4 pixels), with no wrap to x=0.
REQ-030 abort in DRAW cycle 5 -> IDLE next cycle with no done; reset asserted mid-draw -> all outputs 0; a new start afterwards draws normally.
REQ-031 start held high for the whole draw -> exactly one draw, then a new draw begins the cycle after DONE.

Source files
------------

// File: rtl/pixeltyper_pkg.sv
// Shared definitions for the glyph blitter: FSM encoding and the
// encodings of the scale2 magnification select.
package pixeltyper_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic SCALE_1X = 1'b0;
  localparam logic SCALE_2X = 1'b1;

endpackage

// File: rtl/glyph_scan_counter.sv
// Row-major output-offset scanner over a GLYPH_W x GLYPH_H glyph at 1x or 2x.
// Exposes both the current offset and the offset that will follow it.
module glyph_scan_counter
  import pixeltyper_pkg::*;
#(
  parameter int GLYPH_W = 4,
  parameter int GLYPH_H = 4,
  parameter int OX_W    = 3,
  parameter int OY_W    = 3
) (
  input  logic            clk,
  input  logic            reset_i,
  input  logic            adv_i,
  input  logic            scale2_i,
  output logic [OX_W-1:0] ox_o,
  output logic [OY_W-1:0] oy_o,
  output logic [OX_W-1:0] nox_o,
  output logic [OY_W-1:0] noy_o,
  output logic            last_o
);

  logic [OX_W-1:0] ox_q, xmax;
  logic [OY_W-1:0] oy_q, ymax;

  assign xmax = (scale2_i == SCALE_2X) ? OX_W'(2*GLYPH_W-1) : OX_W'(GLYPH_W-1);
  assign ymax = (scale2_i == SCALE_2X) ? OY_W'(2*GLYPH_H-1) : OY_W'(GLYPH_H-1);

  always_comb begin
    nox_o = ox_q + 1'b1;
    noy_o = oy_q;
    if (ox_q == xmax) begin
      nox_o = '0;
      noy_o = oy_q + 1'b1;
    end
  end

  assign last_o = (ox_q == xmax) && (oy_q == ymax);
  assign ox_o   = ox_q;
  assign oy_o   = oy_q;

  // Anything other than an explicit advance parks the scan back at (0,0).
  always_ff @(posedge clk) begin
    if (reset_i || !adv_i) begin
      ox_q <= '0;
      oy_q <= '0;
    end else begin
      ox_q <= nox_o;
      oy_q <= noy_o;
    end
  end

endmodule

// File: rtl/glyph_blitter.sv
// Glyph blitter: rasterises a captured 1bpp glyph, optionally 2x magnified,
// emitting one clipped, registered pixel per DRAW cycle.
module glyph_blitter
  import pixeltyper_pkg::*;
#(
  parameter int GLYPH_W  = 4,
  parameter int GLYPH_H  = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [GLYPH_W*GLYPH_H-1:0] glyph,
  input  logic [X_W-1:0]             x0,
  input  logic [Y_W-1:0]             y0,
  input  logic [COLOUR_W-1:0]        fg,
  input  logic [COLOUR_W-1:0]        bg,
  input  logic                       scale2,
  input  logic                       transparent,
  output logic [X_W-1:0]             plot_x,
  output logic [Y_W-1:0]             plot_y,
  output logic [COLOUR_W-1:0]        plot_colour,
  output logic                       plot,
  output logic                       busy,
  output logic                       done
);

  localparam int GN   = GLYPH_W*GLYPH_H;
  localparam int BI_W = $clog2(GN);
  localparam int OX_W = $clog2(2*GLYPH_W);
  localparam int OY_W = $clog2(2*GLYPH_H);
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_e              state_q;
  logic [GN-1:0]       glyph_q;
  logic [X_W-1:0]      x0_q;
  logic [Y_W-1:0]      y0_q;
  logic [COLOUR_W-1:0] fg_q, bg_q;
  logic                scale_q, transp_q;

  logic [OX_W-1:0] ox, nox;
  logic [OY_W-1:0] oy, noy;
  logic            last, scan_adv;

  assign scan_adv = (state_q == ST_DRAW) && !abort && !last;

  glyph_scan_counter #(
    .GLYPH_W(GLYPH_W), .GLYPH_H(GLYPH_H), .OX_W(OX_W), .OY_W(OY_W)
  ) u_scan (
    .clk     (clk),
    .reset_i (reset),
    .adv_i   (scan_adv),
    .scale2_i(scale_q),
    .ox_o    (ox),
    .oy_o    (oy),
    .nox_o   (nox),
    .noy_o   (noy),
    .last_o  (last)
  );

  // The pixel being computed is the one shown next cycle: pixel 0 straight
  // from the ports on the accepting edge, later pixels from captured state.
  logic [GN-1:0]       s_glyph;
  logic [X_W-1:0]      s_x0;
  logic [Y_W-1:0]      s_y0;
  logic [COLOUR_W-1:0] s_fg, s_bg;
  logic                s_scale, s_tr, sbit;
  logic [OX_W-1:0]     s_ox, cx;
  logic [OY_W-1:0]     s_oy, cy;
  logic [BI_W-1:0]     bidx;
  logic [X_W:0]        wx;
  logic [Y_W:0]        wy;
  logic                pix_plot;
  logic [COLOUR_W-1:0] pix_col;

  always_comb begin
    s_glyph = glyph_q;
    s_x0    = x0_q;
    s_y0    = y0_q;
    s_fg    = fg_q;
    s_bg    = bg_q;
    s_scale = scale_q;
    s_tr    = transp_q;
    s_ox    = nox;
    s_oy    = noy;
    if (state_q == ST_IDLE) begin
      s_glyph = glyph;
      s_x0    = x0;
      s_y0    = y0;
      s_fg    = fg;
      s_bg    = bg;
      s_scale = scale2;
      s_tr    = transparent;
      s_ox    = '0;
      s_oy    = '0;
    end
    cx       = s_ox >> s_scale;
    cy       = s_oy >> s_scale;
    bidx     = BI_W'(cy) * BI_W'(GLYPH_W) + BI_W'(cx);
    sbit     = s_glyph[bidx];
    wx       = {1'b0, s_x0} + (X_W+1)'(s_ox);
    wy       = {1'b0, s_y0} + (Y_W+1)'(s_oy);
    pix_plot = (wx < SCR_W) && (wy < SCR_H) && (sbit || !s_tr);
    pix_col  = sbit ? s_fg : s_bg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      glyph_q     <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      fg_q        <= '0;
      bg_q        <= '0;
      scale_q     <= SCALE_1X;
      transp_q    <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (start && !abort) begin
            state_q     <= ST_DRAW;
            glyph_q     <= glyph;
            x0_q        <= x0;
            y0_q        <= y0;
            fg_q        <= fg;
            bg_q        <= bg;
            scale_q     <= scale2;
            transp_q    <= transparent;
            busy        <= 1'b1;
            plot        <= pix_plot;
            plot_x      <= wx[X_W-1:0];
            plot_y      <= wy[Y_W-1:0];
            plot_colour <= pix_col;
          end
        end
        ST_DRAW: begin
          if (abort) begin
            state_q <= ST_IDLE;
            plot    <= 1'b0;
            busy    <= 1'b0;
          end else if (last) begin
            state_q <= ST_DONE;
            plot    <= 1'b0;
            done    <= 1'b1;
          end else begin
            plot        <= pix_plot;
            plot_x      <= wx[X_W-1:0];
            plot_y      <= wy[Y_W-1:0];
            plot_colour <= pix_col;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          plot    <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_blitter.sv
// Scoreboard bench for glyph_blitter at default parameters.
module tb_glyph_blitter;

  logic        clk = 1'b0;
  logic        reset, start, abort, scale2, transparent;
  logic [15:0] glyph;
  logic [7:0]  x0;
  logic [6:0]  y0;
  logic [2:0]  fg, bg;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        plot, busy, done;

  int nchk = 0;
  int nerr = 0;
  logic [18:0] sb[$];

  always #5 clk = ~clk;

  glyph_blitter dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .glyph(glyph),
    .x0(x0), .y0(y0), .fg(fg), .bg(bg), .scale2(scale2),
    .transparent(transparent), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .plot(plot), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one draw and checks every DRAW cycle against the model queue.
  // abort_at >= 0 aborts in that DRAW cycle; hold keeps start asserted.
  task automatic draw(input logic [15:0] g, input logic [7:0] x, input logic [6:0] y,
                      input logic [2:0] f, input logic [2:0] b, input logic s2,
                      input logic tr, input int abort_at, input logic hold,
                      output int nplot);
    int s;
    logic [18:0] e, got;
    logic bt, p;
    logic [8:0] wx;
    logic [7:0] wy;
    s = s2 ? 2 : 1;
    nplot = 0;
    e = '0;
    for (int oy = 0; oy < 4*s; oy++)
      for (int ox = 0; ox < 4*s; ox++) begin
        bt = g[(oy/s)*4 + ox/s];
        wx = {1'b0, x} + 9'(ox);
        wy = {1'b0, y} + 8'(oy);
        p  = (wx < 9'd160) && (wy < 8'd120) && (bt || !tr);
        sb.push_back({p, wx[7:0], wy[6:0], bt ? f : b});
      end
    glyph = g; x0 = x; y0 = y; fg = f; bg = b; scale2 = s2; transparent = tr;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    glyph = ~g; x0 = x + 8'd37; y0 = y + 7'd5; fg = ~f; bg = ~b;
    scale2 = ~s2; transparent = ~tr;
    for (int k = 0; k < 16*s*s; k++) begin
      e   = sb.pop_front();
      got = {plot, plot_x, plot_y, plot_colour};
      chk("pixel", 32'(got), 32'(e));
      chk("busy_draw", 32'({busy, done}), 32'h2);
      if (plot) nplot++;
      if (k == abort_at) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", 32'({plot, busy, done}), 32'h0);
        @(negedge clk);
        chk("abort_no_done", 32'({plot, busy, done}), 32'h0);
        sb.delete();
        return;
      end
      @(negedge clk);
    end
    chk("done_pulse", 32'({done, plot, busy}), 32'h5);
    @(negedge clk);
    chk("idle_after", 32'({done, plot, busy}), 32'h0);
    chk("idle_hold", 32'({plot_x, plot_y, plot_colour}), 32'(e[17:0]));
  endtask

  initial begin
    int np;
    reset = 1'b1; start = 1'b0; abort = 1'b0; glyph = '0; x0 = '0; y0 = '0;
    fg = '0; bg = '0; scale2 = 1'b0; transparent = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_state", 32'({plot, busy, done, plot_x, plot_y, plot_colour}), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    draw(16'h8001, 8'd100, 7'd10, 3'b111, 3'b001, 1'b0, 1'b0, -1, 1'b0, np);
    chk("opaque_plots", np, 16);
    draw(16'h8001, 8'd100, 7'd10, 3'b111, 3'b001, 1'b0, 1'b1, -1, 1'b0, np);
    chk("transp_plots", np, 2);
    draw(16'h0001, 8'd0, 7'd0, 3'b110, 3'b010, 1'b1, 1'b0, -1, 1'b0, np);
    chk("scale2_plots", np, 64);
    draw(16'h0001, 8'd0, 7'd0, 3'b110, 3'b010, 1'b1, 1'b1, -1, 1'b0, np);
    chk("scale2_transp", np, 4);
    draw(16'hFFFF, 8'd158, 7'd118, 3'b101, 3'b000, 1'b0, 1'b0, -1, 1'b0, np);
    chk("clip_plots", np, 4);
    draw(16'hA5C3, 8'd155, 7'd20, 3'b011, 3'b100, 1'b1, 1'b0, -1, 1'b0, np);
    draw(16'h1234, 8'd40, 7'd40, 3'b111, 3'b001, 1'b0, 1'b0, 5, 1'b0, np);

    // start and abort together in IDLE: nothing may begin
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'({plot, busy, done}), 32'h0);

    // reset mid-draw
    glyph = 16'hFFFF; x0 = 8'd10; y0 = 7'd10; fg = 3'b111; bg = 3'b000;
    scale2 = 1'b0; transparent = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid", 32'({plot, busy, done, plot_x, plot_y, plot_colour}), 32'h0);
    @(negedge clk);
    chk("reset_no_done", 32'({plot, busy, done}), 32'h0);
    draw(16'h0F0F, 8'd20, 7'd30, 3'b010, 3'b101, 1'b0, 1'b0, -1, 1'b0, np);
    chk("post_reset_plots", np, 16);

    // start held throughout: one draw, one IDLE cycle, then the next draw
    draw(16'h8421, 8'd60, 7'd60, 3'b111, 3'b001, 1'b0, 1'b0, -1, 1'b1, np);
    @(negedge clk);
    chk("restart_busy", 32'({busy, done}), 32'h2);
    start = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("restart_abort", 32'({plot, busy, done}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
